// File: rtl/usb_pkg.sv
// Shared definitions for the USB register-file slice: address layout,
// packet limits and the packet framer state encoding.
package usb_pkg;

    localparam int ADDR_W        = 16;
    localparam int BANK_MSB      = 15;
    localparam int BANK_LSB      = 12;
    localparam int MAX_PKT_BYTES = 64;

    typedef enum logic [1:0] {
        S_ADR0,
        S_ADR1,
        S_DATA
    } pkt_state_t;

endpackage

// File: rtl/usb_pkt_framer.sv
// Splits the FX2 byte stream into packets: two little-endian address bytes,
// then data bytes at an auto-incrementing address, ended by an idle timeout.
module usb_pkt_framer
    import usb_pkg::*;
#(
    parameter int IDLE_CLKS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              USB_FWRn,
    input  logic [7:0]        USB_D,
    output logic [7:0]        data_byte,
    output logic [ADDR_W-1:0] byte_adr,
    output logic              data_valid,
    output logic              pkt_start,
    output logic              pkt_end,
    output logic              pkt_active
);

    localparam int CNT_W = $clog2(IDLE_CLKS + 1);

    logic [CNT_W-1:0]  idle_cnt;
    pkt_state_t        state;
    logic [ADDR_W-1:0] adr;
    logic              byte_in;
    logic              timeout;

    // A byte on the would-be timeout cycle keeps the packet alive.
    assign byte_in = ~USB_FWRn;
    assign timeout = USB_FWRn && (idle_cnt == CNT_W'(IDLE_CLKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= CNT_W'(IDLE_CLKS);
        end else if (byte_in) begin
            idle_cnt <= '0;
        end else if (idle_cnt != CNT_W'(IDLE_CLKS)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_ADR0;
            adr        <= '0;
            pkt_active <= 1'b0;
        end else if (timeout) begin
            state      <= S_ADR0;
            pkt_active <= 1'b0;
        end else if (byte_in) begin
            case (state)
                S_ADR0: begin
                    adr[7:0]   <= USB_D;
                    pkt_active <= 1'b1;
                    state      <= S_ADR1;
                end
                S_ADR1: begin
                    adr[ADDR_W-1:8] <= USB_D;
                    state           <= S_DATA;
                end
                S_DATA:  adr   <= adr + 1'b1;
                default: state <= S_ADR0;
            endcase
        end
    end

    assign data_byte  = USB_D;
    assign byte_adr   = adr;
    assign data_valid = byte_in && (state == S_DATA);
    assign pkt_start  = byte_in && (state == S_ADR0);
    assign pkt_end    = timeout;

endmodule

// File: rtl/usb_reg_file.sv
// USB-writable register file: banked address decode, staged lanes so a
// multi-byte register updates atomically on its top byte, sticky map error.
module usb_reg_file
    import usb_pkg::*;
#(
    parameter int NUM_BANKS     = 2,
    parameter int REGS_PER_BANK = 4,
    parameter int REG_WIDTH     = 16,
    parameter int IDLE_CLKS     = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         USB_FWRn,
    input  logic [7:0]                                   USB_D,
    output logic [NUM_BANKS*REGS_PER_BANK*REG_WIDTH-1:0] regs_out,
    output logic [NUM_BANKS*REGS_PER_BANK-1:0]           reg_wr_pulse,
    output logic                                         pkt_active,
    output logic                                         pkt_err
);

    localparam int NUM_REGS   = NUM_BANKS * REGS_PER_BANK;
    localparam int REG_BYTES  = REG_WIDTH / 8;
    localparam int BANK_BYTES = REGS_PER_BANK * REG_BYTES;
    localparam int TOP_LANE   = REG_BYTES - 1;
    localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int LANE_W     = (REG_BYTES > 1) ? $clog2(REG_BYTES) : 1;

    logic [7:0]           data_byte;
    logic [ADDR_W-1:0]    byte_adr;
    logic                 data_valid;
    logic                 pkt_start;
    logic                 pkt_end;

    int                   bank_n;
    int                   off_n;
    logic                 mapped;
    logic [IDX_W-1:0]     idx;
    logic [LANE_W-1:0]    lane;
    logic                 top_lane;
    logic                 stage_hit;
    logic [REG_WIDTH-1:0] commit_val;

    logic [REG_WIDTH-1:0] regs [NUM_REGS];
    logic [REG_WIDTH-1:0] stage_data;
    logic [IDX_W-1:0]     stage_idx;
    logic [REG_BYTES-1:0] stage_mask;

    usb_pkt_framer #(
        .IDLE_CLKS(IDLE_CLKS)
    ) u_framer (
        .clk       (clk),
        .rst       (rst),
        .USB_FWRn  (USB_FWRn),
        .USB_D     (USB_D),
        .data_byte (data_byte),
        .byte_adr  (byte_adr),
        .data_valid(data_valid),
        .pkt_start (pkt_start),
        .pkt_end   (pkt_end),
        .pkt_active(pkt_active)
    );

    // Lanes not staged for this register keep their current contents on commit.
    always_comb begin
        bank_n     = int'(byte_adr[BANK_MSB:BANK_LSB]);
        off_n      = int'(byte_adr[BANK_LSB-1:0]);
        mapped     = (bank_n < NUM_BANKS) && (off_n < BANK_BYTES);
        idx        = IDX_W'(bank_n * REGS_PER_BANK + off_n / REG_BYTES);
        lane       = LANE_W'(off_n % REG_BYTES);
        top_lane   = (lane == LANE_W'(TOP_LANE));
        stage_hit  = (stage_mask != '0) && (stage_idx == idx);
        commit_val = regs[idx];
        for (int l = 0; l < TOP_LANE; l++) begin
            if (stage_hit && stage_mask[l]) begin
                commit_val[l*8 +: 8] = stage_data[l*8 +: 8];
            end
        end
        commit_val[TOP_LANE*8 +: 8] = data_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            reg_wr_pulse <= '0;
            pkt_err      <= 1'b0;
            stage_data   <= '0;
            stage_idx    <= '0;
            stage_mask   <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (pkt_start) begin
                pkt_err <= 1'b0;
            end
            if (pkt_end) begin
                stage_data <= '0;
                stage_mask <= '0;
            end else if (data_valid) begin
                if (!mapped) begin
                    pkt_err <= 1'b1;
                end else if (top_lane) begin
                    regs[idx]         <= commit_val;
                    reg_wr_pulse[idx] <= 1'b1;
                    stage_mask        <= '0;
                end else begin
                    for (int l = 0; l < REG_BYTES; l++) begin
                        if (LANE_W'(l) == lane) begin
                            stage_data[l*8 +: 8] <= data_byte;
                        end
                    end
                    stage_mask <= (stage_hit ? stage_mask : '0) | (REG_BYTES'(1) << lane);
                    stage_idx  <= idx;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_out
        assign regs_out[gi*REG_WIDTH +: REG_WIDTH] = regs[gi];
    end

endmodule

// File: tb/tb_usb_reg_file.sv
// Self-checking bench for usb_reg_file: scripted FX2 packets, with a
// scoreboard of expected commits (register, value, cycle) checked on each pulse.
module tb_usb_reg_file;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         USB_FWRn = 1'b1;
    logic [7:0]   USB_D = 8'h00;
    logic [127:0] regs_out;
    logic [7:0]   reg_wr_pulse;
    logic         pkt_active;
    logic         pkt_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          idx;
        logic [15:0] val;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    usb_reg_file #(
        .NUM_BANKS(2),
        .REGS_PER_BANK(4),
        .REG_WIDTH(16),
        .IDLE_CLKS(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .USB_FWRn    (USB_FWRn),
        .USB_D       (USB_D),
        .regs_out    (regs_out),
        .reg_wr_pulse(reg_wr_pulse),
        .pkt_active  (pkt_active),
        .pkt_err     (pkt_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every pulse must match the oldest pending commit, including its cycle.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                if (reg_wr_pulse[i] === 1'b1) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_pulse: got pulse on reg %0d at cycle %0d, expected none", i, cyc);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (i != e.idx || regs_out[i*16 +: 16] !== e.val || cyc != e.cyc) begin
                            errors++;
                            $display("[TB] FAIL commit: got reg %0d=%h at cycle %0d, expected reg %0d=%h at cycle %0d",
                                     i, regs_out[i*16 +: 16], cyc, e.idx, e.val, e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic drive_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        USB_FWRn = 1'b0;
        USB_D    = b;
    endtask

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            USB_FWRn = 1'b1;
            USB_D    = 8'($urandom);
        end
    endtask

    // Called right after driving a top-lane byte: it is sampled on the next edge.
    task automatic push_exp(input int idx, input logic [15:0] val);
        exp_t e;
        e.idx = idx;
        e.val = val;
        e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        USB_FWRn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (regs_out !== '0) begin errors++; $display("[TB] FAIL reset_regs: got %h expected 0", regs_out); end
        if (reg_wr_pulse !== '0) begin errors++; $display("[TB] FAIL reset_pulse: got %h expected 0", reg_wr_pulse); end
        if (pkt_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active: got %b expected 0", pkt_active); end
        if (pkt_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", pkt_err); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single_write();
        drive_byte(8'h00); drive_byte(8'h00); drive_byte(8'h34);
        drive_byte(8'h12); push_exp(0, 16'h1234);
        checks++;
        if (pkt_active !== 1'b1) begin errors++; $display("[TB] FAIL active_in_pkt: got %b expected 1", pkt_active); end
        drive_idle(10);
        checks += 4;
        if (regs_out[15:0] !== 16'h1234) begin errors++; $display("[TB] FAIL single_reg0: got %h expected 1234", regs_out[15:0]); end
        if (pkt_err !== 1'b0) begin errors++; $display("[TB] FAIL single_err: got %b expected 0", pkt_err); end
        if (pkt_active !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_active: got %b expected 0", pkt_active); end
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL single_pending: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_partial_discard();
        drive_byte(8'h02); drive_byte(8'h10); drive_byte(8'hCD);
        drive_byte(8'hAB); push_exp(5, 16'hABCD);
        drive_idle(10);
        drive_byte(8'h02); drive_byte(8'h10); drive_byte(8'hEF);
        drive_idle(10);
        checks += 2;
        if (regs_out[95:80] !== 16'hABCD) begin errors++; $display("[TB] FAIL partial_reg5: got %h expected abcd", regs_out[95:80]); end
        if (regs_out[15:0] !== 16'h1234) begin errors++; $display("[TB] FAIL partial_reg0: got %h expected 1234", regs_out[15:0]); end
        // Top lane alone: the discarded EF must not reappear in the low lane.
        drive_byte(8'h03); drive_byte(8'h10);
        drive_byte(8'h99); push_exp(5, 16'h99CD);
        drive_idle(10);
        checks += 2;
        if (regs_out[95:80] !== 16'h99CD) begin errors++; $display("[TB] FAIL top_only_reg5: got %h expected 99cd", regs_out[95:80]); end
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL partial_pending: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_burst();
        drive_byte(8'h00); drive_byte(8'h00);
        for (int k = 0; k < 8; k++) begin
            drive_byte(8'(8'h11 * (k + 1)));
            if (k % 2 == 1) push_exp(k / 2, {8'(8'h11 * (k + 1)), 8'(8'h11 * k)});
        end
        drive_idle(10);
        checks += 2;
        if (regs_out[63:0] !== 64'h8877_6655_4433_2211) begin errors++; $display("[TB] FAIL burst_regs: got %h expected 8877665544332211", regs_out[63:0]); end
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL burst_pending: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_error();
        drive_byte(8'h06); drive_byte(8'h00); drive_byte(8'hAA);
        drive_byte(8'hBB); push_exp(3, 16'hBBAA);
        drive_byte(8'hCC); drive_byte(8'hDD);
        drive_idle(10);
        checks += 2;
        if (pkt_err !== 1'b1) begin errors++; $display("[TB] FAIL err_offmap: got %b expected 1", pkt_err); end
        if (regs_out[63:48] !== 16'hBBAA) begin errors++; $display("[TB] FAIL err_reg3: got %h expected bbaa", regs_out[63:48]); end
        drive_byte(8'h00); drive_byte(8'h00);
        checks++;
        if (pkt_err !== 1'b0) begin errors++; $display("[TB] FAIL err_clear: got %b expected 0", pkt_err); end
        drive_byte(8'h44); drive_byte(8'h33); push_exp(0, 16'h3344);
        drive_idle(10);
        drive_byte(8'h00); drive_byte(8'h20); drive_byte(8'h55); drive_byte(8'h66);
        drive_idle(10);
        checks += 3;
        if (pkt_err !== 1'b1) begin errors++; $display("[TB] FAIL err_bank: got %b expected 1", pkt_err); end
        if (regs_out !== {16'h0, 16'h0, 16'h99CD, 16'h0, 16'hBBAA, 16'h6655, 16'h4433, 16'h3344}) begin
            errors++; $display("[TB] FAIL err_regs: got %h expected 0000000099cd0000bbaa665544333344", regs_out);
        end
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL err_pending: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_merge();
        drive_byte(8'h00); drive_byte(8'h00);
        drive_idle(7);
        drive_byte(8'h02); drive_byte(8'h00); push_exp(0, 16'h0002);
        drive_idle(7);
        checks++;
        if (pkt_active !== 1'b1) begin errors++; $display("[TB] FAIL merge_active: got %b expected 1", pkt_active); end
        drive_byte(8'hEE); drive_byte(8'hFF); push_exp(1, 16'hFFEE);
        drive_idle(8);
        drive_byte(8'h04); drive_byte(8'h00); drive_byte(8'h10);
        drive_byte(8'h20); push_exp(2, 16'h2010);
        drive_idle(10);
        checks += 4;
        if (regs_out[15:0] !== 16'h0002) begin errors++; $display("[TB] FAIL merge_reg0: got %h expected 0002", regs_out[15:0]); end
        if (regs_out[31:16] !== 16'hFFEE) begin errors++; $display("[TB] FAIL merge_reg1: got %h expected ffee", regs_out[31:16]); end
        if (regs_out[47:32] !== 16'h2010) begin errors++; $display("[TB] FAIL timeout_reg2: got %h expected 2010", regs_out[47:32]); end
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL merge_pending: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        drive_byte(8'h00); drive_byte(8'h00); drive_byte(8'h34);
        USB_FWRn = 1'b1;
        rst      = 1'b1;
        #1;
        checks += 4;
        if (regs_out !== '0) begin errors++; $display("[TB] FAIL mid_reset_regs: got %h expected 0", regs_out); end
        if (reg_wr_pulse !== '0) begin errors++; $display("[TB] FAIL mid_reset_pulse: got %h expected 0", reg_wr_pulse); end
        if (pkt_active !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_active: got %b expected 0", pkt_active); end
        if (pkt_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_err: got %b expected 0", pkt_err); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive_byte(8'h01); drive_byte(8'h00);
        drive_byte(8'h56); push_exp(0, 16'h5600);
        drive_idle(10);
        drive_byte(8'h00); drive_byte(8'h00); drive_byte(8'h78);
        drive_byte(8'h56); push_exp(0, 16'h5678);
        drive_idle(10);
        checks += 2;
        if (regs_out[15:0] !== 16'h5678) begin errors++; $display("[TB] FAIL post_reset_reg0: got %h expected 5678", regs_out[15:0]); end
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL reset_pending: got %0d pending expected 0", sb.size()); end
    endtask

    initial begin
        $display("[TB] usb_reg_file bench start");
        test_reset();
        test_single_write();
        test_partial_discard();
        test_burst();
        test_error();
        test_merge();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
